uart_rx_ctrl: RTL and testbench

Receive-side frame controller for the UART path. Samples the serial line at a fixed oversampling ratio and sequences start-bit qualification, LSB-first data capture, optional parity and stop-bit checking. Each good byte goes into a one-entry output buffer with a valid/ready handshake, and the block flags framing, parity and overrun errors. It sits between the raw `bit_in` pad and byte consumers such as FIFOs and command decoders.

---
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: synchronizer, start/data/parity/stop sequencing, one-entry output buffer.
// Optional even parity is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl #(
  parameter int unsigned OVERSAMPLE = 4,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] byte_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]          bcnt_q, bcnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   sr_q, sr_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ovr_q, ovr_d, busy_q;
  logic                   good_c, ferr_c;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d, perrp_q, perrp_c;
`endif

  // State and datapath registers; synchronizer idles high so reset never looks like a start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      idx_q     <= '0;
      sr_q      <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      perrp_q   <= 1'b0;
`endif
    end else begin
      sync1_q   <= bit_in;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_c;
      ovr_q     <= ovr_d;
      busy_q    <= (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      perrp_q   <= perrp_c;
`endif
    end
  end

  // Frame sequencing; bcnt free-runs and is cleared at every sample point
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q + CW'(1);
    idx_d   = idx_q;
    sr_d    = sr_q;
    good_c  = 1'b0;
    ferr_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    perrp_c = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        if (!rx_s_q && rx_prev_q) begin
          state_d = S_START;
          idx_d   = '0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (bcnt_q == HALF_LAST) begin
          bcnt_d  = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d = '0;
          sr_d   = {rx_s_q, sr_q[DATA_BITS-1:1]};
          idx_d  = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d  = '0;
          state_d = S_STOP;
          if ((^sr_q) ^ rx_s_q) perr_d = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d  = '0;
          state_d = S_IDLE;
          if (!rx_s_q) begin
            ferr_c = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (perr_q) begin
            perrp_c = 1'b1;
`endif
          end else begin
            good_c = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-entry output buffer: a commit may replace a byte only when it is drained that same cycle
  always_comb begin
    byte_d  = byte_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (good_c) begin
      if (!valid_q || ready_in) begin
        byte_d  = sr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  assign byte_out  = byte_q;
  assign valid_out = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perrp_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (OVERSAMPLE=4, DATA_BITS=8); follows UART_RX_PARITY_EN for frame format.
module tb_uart_rx_ctrl;

  localparam int unsigned OS = 4;
  localparam int unsigned DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned P   = 1;
  localparam int unsigned LAT = 45;
`else
  localparam int unsigned P   = 0;
  localparam int unsigned LAT = 41;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_in = 1'b1;
  logic       ready_in = 1'b0;
  logic [7:0] byte_out;
  logic       valid_out, frame_err, parity_err, overrun, busy;

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in),
    .byte_out(byte_out), .valid_out(valid_out), .ready_in(ready_in),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
  int rise_cyc = -1, last_fall = 0;
  logic [7:0] rise_byte = 8'h00, acc_byte = 8'h00;
  logic valid_prev = 1'b0;

  // Event log sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (valid_out) n_valid++;
    if (valid_out && !valid_prev) begin
      rise_cyc  = cyc;
      rise_byte = byte_out;
    end
    valid_prev = valid_out;
    if (valid_out && ready_in) acc_byte = byte_out;
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (overrun) n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one frame starting at a falling clock edge; returns at the next frame slot
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    last_fall = cyc;
    bit_in = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < int'(DB); i++) begin
      bit_in = d[i];
      repeat (OS) @(negedge clk);
    end
    if (P != 0) begin
      bit_in = par;
      repeat (OS) @(negedge clk);
    end
    bit_in = stp;
    repeat (OS) @(negedge clk);
    bit_in = 1'b1;
  endtask

  int b_valid, b_ferr, b_perr, b_ovr, f;

  task automatic snap();
    b_valid = n_valid;
    b_ferr  = n_ferr;
    b_perr  = n_perr;
    b_ovr   = n_ovr;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_byte", 32'(byte_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Good byte with consumer always ready
    ready_in = 1'b1;
    snap();
    send_frame(8'hA5, ^8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    chk("a5_latency", 32'(rise_cyc - last_fall), 32'(LAT));
    chk("a5_byte", 32'(rise_byte), 32'hA5);
    chk("a5_valid_cycles", 32'(n_valid - b_valid), 32'd1);
    chk("a5_accepted", 32'(acc_byte), 32'hA5);
    chk("a5_no_ferr", 32'(n_ferr - b_ferr), 32'd0);
    chk("a5_no_perr", 32'(n_perr - b_perr), 32'd0);
    chk("a5_no_ovr", 32'(n_ovr - b_ovr), 32'd0);

    // One-clock glitch: false start
    snap();
    f = cyc;
    bit_in = 1'b0;
    @(negedge clk);
    bit_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_e1", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);
    chk("glitch_cycle", 32'(cyc - f), 32'd5);
    chk("glitch_busy_e3", 32'(busy), 32'h0);
    repeat (10) @(negedge clk);
    chk("glitch_no_valid", 32'(n_valid - b_valid), 32'd0);
    chk("glitch_no_ferr", 32'(n_ferr - b_ferr), 32'd0);

    // Stop bit low: framing error, buffer untouched
    snap();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    chk("ferr_pulses", 32'(n_ferr - b_ferr), 32'd1);
    chk("ferr_no_valid", 32'(n_valid - b_valid), 32'd0);
    chk("ferr_byte_kept", 32'(byte_out), 32'hA5);

    // Back-to-back frames into a stalled consumer
    ready_in = 1'b0;
    snap();
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    repeat (4) @(negedge clk);
    chk("ovr_first_byte", 32'(rise_byte), 32'h11);
    chk("ovr_pulses", 32'(n_ovr - b_ovr), 32'd1);
    chk("ovr_valid_held", 32'(valid_out), 32'h1);
    chk("ovr_byte_held", 32'(byte_out), 32'h11);
    chk("ovr_no_ferr", 32'(n_ferr - b_ferr), 32'd0);
    ready_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_drained", 32'(valid_out), 32'h0);
    chk("ovr_accepted", 32'(acc_byte), 32'h11);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity bit is 1
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("par_bad_pulse", 32'(n_perr - b_perr), 32'd1);
    chk("par_bad_no_valid", 32'(n_valid - b_valid), 32'd0);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("par_good_byte", 32'(rise_byte), 32'h07);
    chk("par_good_valid", 32'(n_valid - b_valid), 32'd1);
    chk("par_good_no_perr", 32'(n_perr - b_perr), 32'd0);
`else
    chk("par_tied_low", 32'(n_perr), 32'd0);
`endif

    // Break: line held low for several frame times gives a single framing error
    snap();
    bit_in = 1'b0;
    repeat (3 * (DB + 2 + P) * OS) @(negedge clk);
    chk("brk_ferr", 32'(n_ferr - b_ferr), 32'd1);
    chk("brk_idle", 32'(busy), 32'h0);
    chk("brk_no_valid", 32'(n_valid - b_valid), 32'd0);
    bit_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("brk_release_ferr", 32'(n_ferr - b_ferr), 32'd1);

    // Reset mid-frame with a byte waiting in the buffer
    ready_in = 1'b0;
    send_frame(8'h96, ^8'h96, 1'b1);
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 32'(valid_out), 32'h1);
    chk("pre_rst_byte", 32'(byte_out), 32'h96);
    fork
      send_frame(8'hFF, ^8'hFF, 1'b1);
      begin
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_out), 32'h0);
        chk("midrst_byte", 32'(byte_out), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ferr", 32'(frame_err), 32'h0);
        chk("midrst_ovr", 32'(overrun), 32'h0);
      end
    join
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", 32'(valid_out), 32'h0);
    ready_in = 1'b1;
    snap();
    send_frame(8'h5A, ^8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst_latency", 32'(rise_cyc - last_fall), 32'(LAT));
    chk("post_rst_byte", 32'(rise_byte), 32'h5A);
    chk("post_rst_valid_cycles", 32'(n_valid - b_valid), 32'd1);
    chk("post_rst_no_ferr", 32'(n_ferr - b_ferr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
